// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and load results onto one register-file
// write port. Loads that lose arbitration wait in a small in-order buffer.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 4,
  parameter int DW    = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [AW-1:0]          alu_rd,
  input  logic [DW-1:0]          alu_data,
  output logic                   alu_ready,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_rd,
  input  logic [DW-1:0]          ld_data,
  output logic                   ld_ready,
  output logic [AW-1:0]          write_reg,
  output logic [DW-1:0]          write_data,
  output logic                   reg_write,
  output logic [(2**AW)-1:0]     pend_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    ent_rd_q   [DEPTH];
  logic [DW-1:0]    ent_data_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             reg_write_q, reg_write_d;
  logic [AW-1:0]    write_reg_q, write_reg_d;
  logic [DW-1:0]    write_data_q, write_data_d;
  logic [DEPTH-1:0] occ;
  logic             alu_go, ld_acc, fifo_empty, pop, push, bypass;

  // An entry is live when its distance from the head is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
      logic [PW-1:0] offset;
      assign offset  = PW'(gi) - rd_ptr_q;
      assign occ[gi] = ({1'b0, offset} < count_q);
    end
  endgenerate

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i]) pend_mask[ent_rd_q[i]] = 1'b1;
    end
  end

  assign fifo_count = count_q;
  assign ld_ready   = (count_q < CW'(DEPTH));
  assign alu_ready  = !pend_mask[alu_rd];
  assign fifo_empty = (count_q == '0);
  assign alu_go     = alu_valid && alu_ready;
  assign ld_acc     = ld_valid && ld_ready;
  assign pop        = !alu_go && !fifo_empty;
  assign bypass     = !alu_go && fifo_empty && ld_acc;
  assign push       = ld_acc && !bypass;

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_go) begin
      reg_write_d  = 1'b1;
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
    end else if (pop) begin
      reg_write_d  = 1'b1;
      write_reg_d  = ent_rd_q[rd_ptr_q];
      write_data_d = ent_data_q[rd_ptr_q];
    end else if (bypass) begin
      reg_write_d  = 1'b1;
      write_reg_d  = ld_rd;
      write_data_d = ld_data;
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Payload storage needs no reset: occupancy is derived from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= ld_rd;
      ent_data_q[wr_ptr_q] <= ld_data;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a DEPTH=2 and a DEPTH=4 instance share stimulus and are
// checked against a queue-based model of the write-back rules.
module tb_wb_arbiter;
  localparam int AW = 4;
  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_rd = '0;
  logic [DW-1:0] ld_data = '0;

  logic          a_alu_ready, a_ld_ready, a_reg_write;
  logic [AW-1:0] a_write_reg;
  logic [DW-1:0] a_write_data;
  logic [15:0]   a_pend_mask;
  logic [1:0]    a_fifo_count;
  logic          b_alu_ready, b_ld_ready, b_reg_write;
  logic [AW-1:0] b_write_reg;
  logic [DW-1:0] b_write_data;
  logic [15:0]   b_pend_mask;
  logic [2:0]    b_fifo_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) u_a (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(a_alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(a_ld_ready),
    .write_reg(a_write_reg), .write_data(a_write_data), .reg_write(a_reg_write),
    .pend_mask(a_pend_mask), .fifo_count(a_fifo_count)
  );

  wb_arbiter #(.DEPTH(4), .AW(AW), .DW(DW)) u_b (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(b_alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(b_ld_ready),
    .write_reg(b_write_reg), .write_data(b_write_data), .reg_write(b_reg_write),
    .pend_mask(b_pend_mask), .fifo_count(b_fifo_count)
  );

  // Reference model: index 0 models DEPTH=2, index 1 models DEPTH=4.
  // Buffered loads are kept as an ordered list, oldest at position 0.
  logic [AW-1:0] m_rd   [2][8];
  logic [DW-1:0] m_data [2][8];
  int            m_n    [2];
  logic          e_rw   [2];
  logic [AW-1:0] e_wr   [2];
  logic [DW-1:0] e_wd   [2];

  function automatic int dep(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic logic [15:0] exp_pend(int k);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < m_n[k]; i++) p[m_rd[k][i]] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k]  = 0;
      e_rw[k] = 1'b0;
      e_wr[k] = '0;
      e_wd[k] = '0;
    end
  endtask

  // Applies one clock of the write-back rules to the model, then clocks the DUTs.
  task automatic cycle();
    logic [15:0] p;
    logic        go, acc;
    for (int k = 0; k < 2; k++) begin
      p   = exp_pend(k);
      go  = alu_valid && !p[alu_rd];
      acc = ld_valid && (m_n[k] < dep(k));
      e_rw[k] = 1'b0;
      if (go) begin
        e_rw[k] = 1'b1; e_wr[k] = alu_rd; e_wd[k] = alu_data;
      end else if (m_n[k] > 0) begin
        e_rw[k] = 1'b1; e_wr[k] = m_rd[k][0]; e_wd[k] = m_data[k][0];
        for (int i = 1; i < m_n[k]; i++) begin
          m_rd[k][i-1]   = m_rd[k][i];
          m_data[k][i-1] = m_data[k][i];
        end
        m_n[k]--;
      end else if (acc) begin
        e_rw[k] = 1'b1; e_wr[k] = ld_rd; e_wd[k] = ld_data;
        acc = 1'b0;
      end
      if (acc) begin
        m_rd[k][m_n[k]]   = ld_rd;
        m_data[k][m_n[k]] = ld_data;
        m_n[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = DW'($urandom);
    ld_valid = 1'b1; ld_rd = 4'd5; ld_data = DW'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (a_reg_write !== 1'b0 || b_reg_write !== 1'b0) begin
      fails++; $display("FAIL reset_reg_write: got a=%0b b=%0b, expected 0", a_reg_write, b_reg_write);
    end
    tests++;
    if (a_write_reg !== '0 || a_write_data !== '0 || b_write_reg !== '0 || b_write_data !== '0) begin
      fails++; $display("FAIL reset_write_bus: got a=%0h/%0h b=%0h/%0h, expected 0", a_write_reg, a_write_data, b_write_reg, b_write_data);
    end
    tests++;
    if (a_fifo_count !== 2'd0 || b_fifo_count !== 3'd0 || a_pend_mask !== 16'h0 || b_pend_mask !== 16'h0) begin
      fails++; $display("FAIL reset_fifo: got cnt a=%0d b=%0d pend a=%h b=%h, expected 0", a_fifo_count, b_fifo_count, a_pend_mask, b_pend_mask);
    end
    tests++;
    if (a_ld_ready !== 1'b1 || b_ld_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ld_ready: got a=%0b b=%0b, expected 1", a_ld_ready, b_ld_ready);
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle();
    tests++;
    if (a_reg_write !== 1'b0) begin
      fails++; $display("FAIL reset_first_idle: got reg_write=%0b, expected 0", a_reg_write);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_bypass();
    ld_valid = 1'b1; ld_rd = 4'd3; ld_data = 19'h1ABCD;
    #1;
    tests++;
    if (a_ld_ready !== 1'b1) begin
      fails++; $display("FAIL bypass_ld_ready: got %0b, expected 1", a_ld_ready);
    end
    cycle();
    ld_valid = 1'b0;
    tests++;
    if (a_reg_write !== 1'b1 || a_write_reg !== 4'd3 || a_write_data !== 19'h1ABCD) begin
      fails++; $display("FAIL bypass_write: got rw=%0b r%0d=%h, expected 1 r3=1abcd", a_reg_write, a_write_reg, a_write_data);
    end
    tests++;
    if (a_fifo_count !== 2'd0 || a_pend_mask !== 16'h0 || b_fifo_count !== 3'd0) begin
      fails++; $display("FAIL bypass_count: got a=%0d b=%0d pend=%h, expected 0", a_fifo_count, b_fifo_count, a_pend_mask);
    end
    cycle();
    tests++;
    if (a_reg_write !== 1'b0 || a_write_reg !== 4'd3 || a_write_data !== 19'h1ABCD) begin
      fails++; $display("FAIL bypass_hold: got rw=%0b r%0d=%h, expected 0 r3=1abcd", a_reg_write, a_write_reg, a_write_data);
    end
    $display("[TB] test_bypass done");
  endtask

  task automatic test_contention();
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 19'h00011;
    ld_valid = 1'b1; ld_rd = 4'd2; ld_data = 19'h00022;
    #1;
    tests++;
    if (a_alu_ready !== 1'b1) begin
      fails++; $display("FAIL contention_alu_ready: got %0b, expected 1", a_alu_ready);
    end
    cycle();
    alu_valid = 1'b0; ld_valid = 1'b0;
    tests++;
    if (a_reg_write !== 1'b1 || a_write_reg !== 4'd1 || a_write_data !== 19'h00011) begin
      fails++; $display("FAIL contention_alu_write: got rw=%0b r%0d=%h, expected 1 r1=11", a_reg_write, a_write_reg, a_write_data);
    end
    tests++;
    if (a_fifo_count !== 2'd1 || a_pend_mask !== 16'h0004) begin
      fails++; $display("FAIL contention_buffered: got cnt=%0d pend=%h, expected 1 0004", a_fifo_count, a_pend_mask);
    end
    cycle();
    tests++;
    if (a_reg_write !== 1'b1 || a_write_reg !== 4'd2 || a_write_data !== 19'h00022 || a_fifo_count !== 2'd0) begin
      fails++; $display("FAIL contention_ld_write: got rw=%0b r%0d=%h cnt=%0d, expected 1 r2=22 0", a_reg_write, a_write_reg, a_write_data, a_fifo_count);
    end
    cycle();
    $display("[TB] test_contention done");
  endtask

  task automatic test_full();
    logic [DW-1:0] ldv [3];
    int            idx = 0;
    int            got = 0;
    logic          acc;
    for (int i = 0; i < 3; i++) ldv[i] = DW'($urandom);
    alu_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      alu_rd = 4'd0; alu_data = DW'($urandom);
      ld_valid = (idx < 3); ld_rd = AW'(5 + idx); ld_data = ldv[(idx < 3) ? idx : 0];
      #1;
      acc = ld_valid && a_ld_ready;
      if (c >= 2) begin
        tests++;
        if (a_ld_ready !== 1'b0) begin
          fails++; $display("FAIL full_ld_ready c%0d: got %0b, expected 0", c, a_ld_ready);
        end
      end
      cycle();
      if (acc) idx++;
      tests++;
      if (a_reg_write !== 1'b1 || a_write_reg !== 4'd0 || a_write_data !== alu_data) begin
        fails++; $display("FAIL full_alu_write c%0d: got rw=%0b r%0d=%h, expected 1 r0=%h", c, a_reg_write, a_write_reg, a_write_data, alu_data);
      end
    end
    tests++;
    if (idx !== 2 || a_fifo_count !== 2'd2 || a_pend_mask !== 16'h0060) begin
      fails++; $display("FAIL full_state: got accepted=%0d cnt=%0d pend=%h, expected 2 2 0060", idx, a_fifo_count, a_pend_mask);
    end
    alu_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ld_valid = (idx < 3); ld_rd = AW'(5 + idx); ld_data = ldv[(idx < 3) ? idx : 0];
      #1;
      acc = ld_valid && a_ld_ready;
      cycle();
      if (acc) idx++;
      if (a_reg_write === 1'b1) begin
        tests++;
        if (got >= 3 || a_write_reg !== AW'(5 + got) || a_write_data !== ldv[(got < 3) ? got : 0]) begin
          fails++; $display("FAIL full_drain_order #%0d: got r%0d=%h, expected r%0d", got, a_write_reg, a_write_data, 5 + got);
        end
        got++;
      end
    end
    ld_valid = 1'b0;
    tests++;
    if (got !== 3 || idx !== 3) begin
      fails++; $display("FAIL full_drain_total: got writes=%0d accepted=%0d, expected 3 3", got, idx);
    end
    repeat (4) cycle();
    $display("[TB] test_full done");
  endtask

  task automatic test_hazard();
    logic [DW-1:0] d1, d2;
    d1 = DW'($urandom); d2 = DW'($urandom);
    alu_valid = 1'b1; alu_rd = 4'd9; alu_data = DW'($urandom);
    ld_valid = 1'b1; ld_rd = 4'd4; ld_data = d1;
    #1;
    cycle();
    ld_valid = 1'b0;
    tests++;
    if (a_fifo_count !== 2'd1 || a_pend_mask !== 16'h0010) begin
      fails++; $display("FAIL hazard_buffered: got cnt=%0d pend=%h, expected 1 0010", a_fifo_count, a_pend_mask);
    end
    alu_rd = 4'd4; alu_data = d2;
    #1;
    tests++;
    if (a_alu_ready !== 1'b0) begin
      fails++; $display("FAIL hazard_alu_blocked: got %0b, expected 0", a_alu_ready);
    end
    cycle();
    tests++;
    if (a_reg_write !== 1'b1 || a_write_reg !== 4'd4 || a_write_data !== d1) begin
      fails++; $display("FAIL hazard_load_first: got rw=%0b r%0d=%h, expected 1 r4=%h", a_reg_write, a_write_reg, a_write_data, d1);
    end
    tests++;
    if (a_alu_ready !== 1'b1) begin
      fails++; $display("FAIL hazard_alu_released: got %0b, expected 1", a_alu_ready);
    end
    cycle();
    alu_valid = 1'b0;
    tests++;
    if (a_reg_write !== 1'b1 || a_write_reg !== 4'd4 || a_write_data !== d2) begin
      fails++; $display("FAIL hazard_alu_second: got rw=%0b r%0d=%h, expected 1 r4=%h", a_reg_write, a_write_reg, a_write_data, d2);
    end
    cycle();
    $display("[TB] test_hazard done");
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 4'd0;
    for (int c = 0; c < 2; c++) begin
      alu_data = DW'($urandom);
      ld_valid = 1'b1; ld_rd = AW'(8 + c); ld_data = DW'($urandom);
      #1;
      cycle();
    end
    tests++;
    if (a_fifo_count !== 2'd2) begin
      fails++; $display("FAIL reset_mid_fill: got cnt=%0d, expected 2", a_fifo_count);
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    tests++;
    if (a_reg_write !== 1'b0 || a_fifo_count !== 2'd0 || a_pend_mask !== 16'h0 || a_ld_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid_async: got rw=%0b cnt=%0d pend=%h rdy=%0b, expected 0 0 0 1", a_reg_write, a_fifo_count, a_pend_mask, a_ld_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      tests++;
      if (a_reg_write !== 1'b0 || b_reg_write !== 1'b0) begin
        fails++; $display("FAIL reset_mid_no_write c%0d: got a=%0b b=%0b, expected 0", c, a_reg_write, b_reg_write);
      end
    end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_wrap();
    logic [AW-1:0] lrd [10];
    logic [DW-1:0] ldv [10];
    int            idx = 0;
    int            got = 0;
    int            maxc = 0;
    logic          acc, av;
    for (int i = 0; i < 10; i++) begin
      lrd[i] = AW'($urandom_range(1, 15));
      ldv[i] = DW'($urandom);
    end
    for (int c = 0; c < 60; c++) begin
      if (got == 10 && idx == 10) break;
      alu_valid = (c < 8) || ((c % 3 == 0) && (c < 24));
      alu_rd = 4'd0; alu_data = DW'($urandom);
      ld_valid = (idx < 10); ld_rd = lrd[(idx < 10) ? idx : 0]; ld_data = ldv[(idx < 10) ? idx : 0];
      #1;
      acc = ld_valid && b_ld_ready;
      av  = alu_valid;
      cycle();
      if (acc) idx++;
      if (int'(b_fifo_count) > maxc) maxc = int'(b_fifo_count);
      tests++;
      if (b_fifo_count > 3'd4) begin
        fails++; $display("FAIL wrap_count_bound c%0d: got %0d, expected <=4", c, b_fifo_count);
      end
      if (b_reg_write === 1'b1 && !av) begin
        tests++;
        if (got >= 10 || b_write_reg !== lrd[(got < 10) ? got : 0] || b_write_data !== ldv[(got < 10) ? got : 0]) begin
          fails++; $display("FAIL wrap_order #%0d: got r%0d=%h, expected r%0d=%h", got, b_write_reg, b_write_data, lrd[(got < 10) ? got : 0], ldv[(got < 10) ? got : 0]);
        end
        got++;
      end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    tests++;
    if (got !== 10 || maxc !== 4) begin
      fails++; $display("FAIL wrap_total: got writes=%0d peak=%0d, expected 10 4", got, maxc);
    end
    repeat (2) cycle();
    $display("[TB] test_wrap done");
  endtask

  task automatic test_random();
    logic          g_rw, g_ar, g_lr;
    logic [AW-1:0] g_wr;
    logic [DW-1:0] g_wd;
    logic [15:0]   g_pm, p;
    int            g_fc;
    for (int c = 0; c < 400; c++) begin
      alu_valid = 1'($urandom_range(0, 1)); alu_rd = AW'($urandom_range(0, 3)); alu_data = DW'($urandom);
      ld_valid = 1'($urandom_range(0, 1)); ld_rd = AW'($urandom_range(0, 3)); ld_data = DW'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        g_ar = (k == 0) ? a_alu_ready : b_alu_ready;
        g_lr = (k == 0) ? a_ld_ready : b_ld_ready;
        p = exp_pend(k);
        tests++;
        if (g_ar !== !p[alu_rd] || g_lr !== (m_n[k] < dep(k))) begin
          fails++; $display("FAIL random_ready d%0d c%0d: got alu=%0b ld=%0b, expected %0b %0b", dep(k), c, g_ar, g_lr, !p[alu_rd], m_n[k] < dep(k));
        end
      end
      cycle();
      for (int k = 0; k < 2; k++) begin
        g_rw = (k == 0) ? a_reg_write : b_reg_write;
        g_wr = (k == 0) ? a_write_reg : b_write_reg;
        g_wd = (k == 0) ? a_write_data : b_write_data;
        g_pm = (k == 0) ? a_pend_mask : b_pend_mask;
        g_fc = (k == 0) ? int'(a_fifo_count) : int'(b_fifo_count);
        tests++;
        if (g_rw !== e_rw[k] || g_wr !== e_wr[k] || g_wd !== e_wd[k] || g_pm !== exp_pend(k) || g_fc != m_n[k]) begin
          fails++; $display("FAIL random_state d%0d c%0d: got rw=%0b r%0d=%h pend=%h cnt=%0d, expected rw=%0b r%0d=%h pend=%h cnt=%0d",
                            dep(k), c, g_rw, g_wr, g_wd, g_pm, g_fc, e_rw[k], e_wr[k], e_wd[k], exp_pend(k), m_n[k]);
        end
      end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    $display("[TB] test_random done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bypass();
    test_contention();
    test_full();
    test_hazard();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
